pc_sequencer: RTL

Parametrised program-counter and instruction-fetch sequencer for the lab4 MIPS datapath. It holds the PC, issues one outstanding word fetch at a time to instruction memory over a req/ack handshake, and applies resolved control-flow decisions from decode: j, jr and bgt. An optional branch delay slot is supported. It replaces the separate combinational jump/jr/branch next-address blocks with one sequential unit.

---
 rtl/lab4_pkg.sv | 20 ++
 rtl/pc_target_calc.sv | 49 ++++
 rtl/pc_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/lab4_pkg.sv
// Shared definitions for the lab4 fetch path: control-flow opcodes, sequencer
// states and the instruction word size.
package lab4_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_J    = 2'b01,
    OP_JR   = 2'b10,
    OP_BGT  = 2'b11
  } ctl_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect resolution for j, jr and bgt: computes whether the
// control-flow instruction redirects, where to, and whether a jr target is misaligned.
module pc_target_calc
  import lab4_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [1:0]        ctl_op_i,
  input  logic [ADDR_W-1:0] ctl_pc_i,
  input  logic [25:0]       ctl_target_i,
  input  logic [15:0]       ctl_offset_i,
  input  logic [31:0]       rs_val_i,
  input  logic [31:0]       rt_val_i,
  output logic [ADDR_W-1:0] target_o,
  output logic              taken_o,
  output logic              misaligned_o
);

  logic [ADDR_W-1:0] p4;
  logic [ADDR_W-1:0] branch_off;

  assign p4         = ctl_pc_i + ADDR_W'(WORD_BYTES);
  assign branch_off = {{(ADDR_W-16){ctl_offset_i[15]}}, ctl_offset_i} << 2;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    target_o     = '0;
    taken_o      = 1'b0;
    misaligned_o = 1'b0;
    case (ctl_op_i)
      OP_J: begin
        taken_o  = 1'b1;
        target_o = {p4[ADDR_W-1:28], ctl_target_i, 2'b00};
      end
      OP_JR: begin
        taken_o      = 1'b1;
        target_o     = {rs_val_i[ADDR_W-1:2], 2'b00};
        misaligned_o = |rs_val_i[1:0];
      end
      OP_BGT: begin
        taken_o  = $signed(rs_val_i) > $signed(rt_val_i);
        target_o = p4 + branch_off;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and single-outstanding instruction fetch sequencer with
// j/jr/bgt redirects and an optional branch delay slot.
module pc_sequencer
  import lab4_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                DELAY_SLOT = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic              stall,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] fetch_pc,
  input  logic              ctl_valid,
  input  logic [1:0]        ctl_op,
  input  logic [ADDR_W-1:0] ctl_pc,
  input  logic [25:0]       ctl_target,
  input  logic [15:0]       ctl_offset,
  input  logic [31:0]       ctl_rs_val,
  input  logic [31:0]       ctl_rt_val,
  output logic              taken,
  output logic              flush,
  output logic              addr_err,
  output logic              ctl_conflict
);

  localparam bit DS = (DELAY_SLOT != 0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              slot_q, slot_d;
  logic              kill_q, kill_d;
  logic              fv_q, fv_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic              taken_q, taken_d;
  logic              flush_q, flush_d;
  logic              err_q, err_d;
  logic              conf_q, conf_d;

  logic [ADDR_W-1:0] calc_target;
  logic              calc_taken;
  logic              calc_misaligned;

  pc_target_calc #(.ADDR_W(ADDR_W)) u_calc (
    .ctl_op_i     (ctl_op),
    .ctl_pc_i     (ctl_pc),
    .ctl_target_i (ctl_target),
    .ctl_offset_i (ctl_offset),
    .rs_val_i     (ctl_rs_val),
    .rt_val_i     (ctl_rt_val),
    .target_o     (calc_target),
    .taken_o      (calc_taken),
    .misaligned_o (calc_misaligned)
  );

  logic              hit, accept, issue;
  logic              pend_eff, slot_eff;
  logic [ADDR_W-1:0] tgt_eff;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    req_d   = req_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;
    slot_d  = slot_q;
    kill_d  = kill_q;
    fv_d    = 1'b0;
    fpc_d   = fpc_q;
    issue   = 1'b0;

    hit     = ctl_valid && calc_taken;
    accept  = hit && !pend_q;
    taken_d = accept;
    flush_d = accept && !DS;
    err_d   = ctl_valid && (ctl_op == OP_JR) && calc_misaligned;
    conf_d  = hit && pend_q;

    // A redirect accepted this cycle already steers an address issued this cycle.
    pend_eff = pend_q || accept;
    tgt_eff  = pend_q ? tgt_q  : calc_target;
    slot_eff = pend_q ? slot_q : (DS && (addr_q == ctl_pc));

    if (accept) begin
      pend_d = 1'b1;
      tgt_d  = calc_target;
      slot_d = DS && (addr_q == ctl_pc);
      if (!DS && (state_q == REQ) && !imem_ack) kill_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
      end
      REQ: begin
        if (imem_ack) begin
          fv_d   = !kill_q;
          fpc_d  = kill_q ? fpc_q : addr_q;
          kill_d = 1'b0;
          if (stall) begin
            state_d = HOLD;
            req_d   = 1'b0;
          end else begin
            issue = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!stall) issue = 1'b1;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (issue) begin
      state_d = REQ;
      req_d   = 1'b1;
      if (pend_eff && !slot_eff) begin
        addr_d = tgt_eff;
        pend_d = 1'b0;
        slot_d = 1'b0;
      end else begin
        addr_d = addr_q + ADDR_W'(WORD_BYTES);
        slot_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      pend_q  <= 1'b0;
      tgt_q   <= '0;
      slot_q  <= 1'b0;
      kill_q  <= 1'b0;
      fv_q    <= 1'b0;
      fpc_q   <= '0;
      taken_q <= 1'b0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
      conf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
      slot_q  <= slot_d;
      kill_q  <= kill_d;
      fv_q    <= fv_d;
      fpc_q   <= fpc_d;
      taken_q <= taken_d;
      flush_q <= flush_d;
      err_q   <= err_d;
      conf_q  <= conf_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = addr_q;
  assign fetch_valid  = fv_q;
  assign fetch_pc     = fpc_q;
  assign taken        = taken_q;
  assign flush        = flush_q;
  assign addr_err     = err_q;
  assign ctl_conflict = conf_q;

endmodule
